arm_mc_ctrl_ls: RTL and testbench

Multi-cycle control FSM for the ARM-subset datapath. It is the successor of the current fetch/decode/execute controller and keeps data-processing, B, BL and BX support. It adds LDR/STR with a memory request/ready handshake, a bounded wait timeout with fault reporting, and condition-fail skipping for every instruction class. All outputs are registered on the rising edge of the single clock.

---
 rtl/arm_ctrl_pkg.sv | 45 ++++
 rtl/mem_wait_timer.sv | 29 ++
 rtl/arm_mc_ctrl_ls.sv | 215 +++++++++++++++++++++
 tb/tb_arm_mc_ctrl_ls.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_ctrl_pkg.sv
// rtl/arm_ctrl_pkg.sv - shared types, codes and decode helpers for the ARM-subset controller
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_BX,
        ST_B_CALC,
        ST_B_WRPC,
        ST_BL_LINK,
        ST_BL_CALC,
        ST_MEM_ADDR,
        ST_MEM_WAIT,
        ST_MEM_WB,
        ST_FAULT
    } state_t;

    localparam logic [3:0] ALU_CODE_ADD    = 4'b0100;
    localparam logic [3:0] ALU_CODE_SUB    = 4'b0010;
    localparam logic [3:0] ALU_CODE_PASS_A = 4'b1000;

    localparam logic [1:0] PC_S_INC  = 2'b00;
    localparam logic [1:0] PC_S_BREG = 2'b01;
    localparam logic [1:0] PC_S_ALU  = 2'b10;

    function automatic logic is_b(input logic [31:0] ir);
        return ir[27:24] == 4'b1010;
    endfunction

    function automatic logic is_bl(input logic [31:0] ir);
        return ir[27:24] == 4'b1011;
    endfunction

    function automatic logic is_bx(input logic [31:0] ir);
        return ir[27:4] == 24'h12FFF1;
    endfunction

    function automatic logic is_mem(input logic [31:0] ir);
        return ir[27:26] == 2'b01;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - bounded wait counter for the memory handshake
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic active,
    input  logic mem_ready,
    output logic expire
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // Saturates at LAST; the FSM leaves MEM_WAIT on that same cycle anyway.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (active && !mem_ready && cnt != LAST) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expire = active && !mem_ready && (cnt == LAST);

endmodule

// File: rtl/arm_mc_ctrl_ls.sv
// rtl/arm_mc_ctrl_ls.sv - multi-cycle fetch/decode/execute/load-store control FSM
module arm_mc_ctrl_ls
    import arm_ctrl_pkg::*;
#(
    parameter int ALU_OP_W    = 4,
    parameter int SHIFT_OP_W  = 3,
    parameter int MEM_TIMEOUT = 16,
    parameter logic [ALU_OP_W-1:0] ALU_ADD    = ALU_OP_W'(4'b0100),
    parameter logic [ALU_OP_W-1:0] ALU_PASS_A = ALU_OP_W'(4'b1000)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           ir,
    input  logic                  ir_valid,
    input  logic                  cond_fail,
    input  logic                  rm_imm_s,
    input  logic [1:0]            rs_imm_s,
    input  logic [SHIFT_OP_W-1:0] shift_op,
    input  logic [ALU_OP_W-1:0]   alu_op,
    input  logic                  s_bit,
    input  logic                  mem_ready,
    output logic                  write_pc,
    output logic                  write_ir,
    output logic                  write_reg,
    output logic                  la,
    output logic                  lb,
    output logic                  lc,
    output logic                  lf,
    output logic                  l_mdr,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [1:0]            pc_s,
    output logic                  alu_a_s,
    output logic                  alu_b_s,
    output logic                  rd_s,
    output logic                  wd_s,
    output logic                  s_ctrl,
    output logic                  rm_imm_s_ctrl,
    output logic [1:0]            rs_imm_s_ctrl,
    output logic [SHIFT_OP_W-1:0] shift_op_ctrl,
    output logic [ALU_OP_W-1:0]   alu_op_ctrl,
    output logic                  fault
);

    localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(ALU_CODE_SUB);

    state_t state;
    state_t next_state;
    logic   expire;
    logic   unused_ir;

    assign unused_ir = ^{ir[31:28], ir[3:0]};

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (state == ST_MEM_ADDR),
        .active    (state == ST_MEM_WAIT),
        .mem_ready (mem_ready),
        .expire    (expire)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:     next_state = ST_FETCH;
            ST_FETCH: begin
                if (ir_valid && !cond_fail) begin
                    if (is_b(ir))       next_state = ST_B_CALC;
                    else if (is_bl(ir)) next_state = ST_BL_LINK;
                    else                next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (is_bx(ir))       next_state = ST_BX;
                else if (is_mem(ir)) next_state = ST_MEM_ADDR;
                else                 next_state = ST_EXEC;
            end
            ST_EXEC:     next_state = cond_fail ? ST_FETCH : ST_WB;
            ST_WB:       next_state = ST_FETCH;
            ST_BX:       next_state = ST_FETCH;
            ST_B_CALC:   next_state = ST_B_WRPC;
            ST_B_WRPC:   next_state = ST_FETCH;
            ST_BL_LINK:  next_state = ST_BL_CALC;
            ST_BL_CALC:  next_state = ST_B_WRPC;
            ST_MEM_ADDR: next_state = ST_MEM_WAIT;
            // mem_we holds ~L for the whole wait, so it doubles as the load/store flag.
            ST_MEM_WAIT: begin
                if (mem_ready)   next_state = mem_we ? ST_FETCH : ST_MEM_WB;
                else if (expire) next_state = ST_FAULT;
            end
            ST_MEM_WB:   next_state = ST_FETCH;
            ST_FAULT:    next_state = ST_FAULT;
            default:     next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            write_pc      <= 1'b0;
            write_ir      <= 1'b0;
            write_reg     <= 1'b0;
            la            <= 1'b0;
            lb            <= 1'b0;
            lc            <= 1'b0;
            lf            <= 1'b0;
            l_mdr         <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            pc_s          <= 2'b00;
            alu_a_s       <= 1'b0;
            alu_b_s       <= 1'b0;
            rd_s          <= 1'b0;
            wd_s          <= 1'b0;
            s_ctrl        <= 1'b0;
            rm_imm_s_ctrl <= 1'b0;
            rs_imm_s_ctrl <= 2'b00;
            shift_op_ctrl <= '0;
            alu_op_ctrl   <= '0;
            fault         <= 1'b0;
        end else begin
            state     <= next_state;
            write_pc  <= 1'b0;
            write_ir  <= 1'b0;
            write_reg <= 1'b0;
            la        <= 1'b0;
            lb        <= 1'b0;
            lc        <= 1'b0;
            lf        <= 1'b0;
            l_mdr     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            case (next_state)
                ST_FETCH: begin
                    write_pc <= 1'b1;
                    write_ir <= 1'b1;
                    pc_s     <= PC_S_INC;
                end
                ST_DECODE: begin
                    la <= 1'b1;
                    lb <= 1'b1;
                    lc <= 1'b1;
                end
                ST_EXEC: begin
                    lf            <= 1'b1;
                    rm_imm_s_ctrl <= rm_imm_s;
                    rs_imm_s_ctrl <= rs_imm_s;
                    shift_op_ctrl <= shift_op;
                    alu_op_ctrl   <= alu_op;
                    s_ctrl        <= s_bit;
                end
                ST_WB: begin
                    write_reg <= 1'b1;
                    wd_s      <= 1'b0;
                    rd_s      <= 1'b0;
                end
                ST_BX: begin
                    write_pc <= 1'b1;
                    pc_s     <= PC_S_BREG;
                end
                ST_B_CALC: begin
                    alu_a_s     <= 1'b1;
                    alu_b_s     <= 1'b1;
                    alu_op_ctrl <= ALU_ADD;
                    s_ctrl      <= 1'b0;
                    lf          <= 1'b1;
                end
                ST_BL_LINK: begin
                    alu_a_s     <= 1'b1;
                    alu_op_ctrl <= ALU_PASS_A;
                    s_ctrl      <= 1'b0;
                    lf          <= 1'b1;
                end
                ST_BL_CALC: begin
                    alu_a_s     <= 1'b1;
                    alu_b_s     <= 1'b1;
                    alu_op_ctrl <= ALU_ADD;
                    s_ctrl      <= 1'b0;
                    lf          <= 1'b1;
                    write_reg   <= 1'b1;
                    rd_s        <= 1'b1;
                    wd_s        <= 1'b0;
                end
                ST_B_WRPC: begin
                    write_pc <= 1'b1;
                    pc_s     <= PC_S_ALU;
                    alu_a_s  <= 1'b0;
                    alu_b_s  <= 1'b0;
                    rd_s     <= 1'b0;
                end
                ST_MEM_ADDR: begin
                    rm_imm_s_ctrl <= ~ir[25];
                    shift_op_ctrl <= '0;
                    alu_op_ctrl   <= ir[23] ? ALU_ADD : ALU_SUB;
                    s_ctrl        <= 1'b0;
                    lf            <= 1'b1;
                end
                ST_MEM_WAIT: begin
                    mem_req <= 1'b1;
                    mem_we  <= (state == ST_MEM_WAIT) ? mem_we : ~ir[20];
                end
                ST_MEM_WB: begin
                    write_reg <= 1'b1;
                    wd_s      <= 1'b1;
                    rd_s      <= 1'b0;
                    l_mdr     <= (state == ST_MEM_WAIT);
                end
                ST_FAULT: fault <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_arm_mc_ctrl_ls.sv
// tb/tb_arm_mc_ctrl_ls.sv - scoreboard bench for arm_mc_ctrl_ls
module tb_arm_mc_ctrl_ls;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ir;
    logic        ir_valid, cond_fail, rm_imm_s, s_bit, mem_ready;
    logic [1:0]  rs_imm_s;
    logic [2:0]  shift_op;
    logic [3:0]  alu_op;
    logic        write_pc, write_ir, write_reg, la, lb, lc, lf, l_mdr;
    logic        mem_req, mem_we, alu_a_s, alu_b_s, rd_s, wd_s;
    logic        s_ctrl, rm_imm_s_ctrl, fault;
    logic [1:0]  pc_s, rs_imm_s_ctrl;
    logic [2:0]  shift_op_ctrl;
    logic [3:0]  alu_op_ctrl;

    arm_mc_ctrl_ls #(.MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .ir(ir), .ir_valid(ir_valid), .cond_fail(cond_fail),
        .rm_imm_s(rm_imm_s), .rs_imm_s(rs_imm_s), .shift_op(shift_op), .alu_op(alu_op),
        .s_bit(s_bit), .mem_ready(mem_ready),
        .write_pc(write_pc), .write_ir(write_ir), .write_reg(write_reg),
        .la(la), .lb(lb), .lc(lc), .lf(lf), .l_mdr(l_mdr),
        .mem_req(mem_req), .mem_we(mem_we), .pc_s(pc_s),
        .alu_a_s(alu_a_s), .alu_b_s(alu_b_s), .rd_s(rd_s), .wd_s(wd_s),
        .s_ctrl(s_ctrl), .rm_imm_s_ctrl(rm_imm_s_ctrl), .rs_imm_s_ctrl(rs_imm_s_ctrl),
        .shift_op_ctrl(shift_op_ctrl), .alu_op_ctrl(alu_op_ctrl), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] stb;
        logic [1:0]  pc_s;
        logic        rd_s, wd_s, a_s, b_s, s_c, rm_c;
        logic [1:0]  rs_c;
        logic [2:0]  sh_c;
        logic [3:0]  aop;
    } obs_t;

    typedef struct {
        string tag;
        obs_t  v;
        obs_t  m;
    } exp_t;

    localparam logic [10:0] WPC = 11'h400, WIR = 11'h200, WREG = 11'h100;
    localparam logic [10:0] LA = 11'h080, LB = 11'h040, LC = 11'h020, LF = 11'h010;
    localparam logic [10:0] LMDR = 11'h008, MREQ = 11'h004, MWE = 11'h002, FLT = 11'h001;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    exp_t cur;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.stb  = {write_pc, write_ir, write_reg, la, lb, lc, lf, l_mdr, mem_req, mem_we, fault};
        o.pc_s = pc_s;
        o.rd_s = rd_s;
        o.wd_s = wd_s;
        o.a_s  = alu_a_s;
        o.b_s  = alu_b_s;
        o.s_c  = s_ctrl;
        o.rm_c = rm_imm_s_ctrl;
        o.rs_c = rs_imm_s_ctrl;
        o.sh_c = shift_op_ctrl;
        o.aop  = alu_op_ctrl;
        return o;
    endfunction

    function automatic exp_t ex(input string tag, input logic [10:0] stb);
        exp_t r;
        r.tag = tag;
        r.v = '0;
        r.m = '0;
        r.v.stb = stb;
        r.m.stb = '1;
        return r;
    endfunction

    function automatic exp_t zero_all(input string tag);
        exp_t r;
        r.tag = tag;
        r.v = '0;
        r.m = '1;
        return r;
    endfunction

    function automatic exp_t pc(input exp_t x, input logic [1:0] v);
        x.v.pc_s = v; x.m.pc_s = '1;
        return x;
    endfunction

    function automatic exp_t rdwd(input exp_t x, input logic rd, input logic wd);
        x.v.rd_s = rd; x.m.rd_s = 1'b1;
        x.v.wd_s = wd; x.m.wd_s = 1'b1;
        return x;
    endfunction

    function automatic exp_t ab(input exp_t x, input logic a, input logic b, input logic [3:0] aop);
        x.v.a_s = a;   x.m.a_s = 1'b1;
        x.v.b_s = b;   x.m.b_s = 1'b1;
        x.v.aop = aop; x.m.aop = '1;
        x.v.s_c = 1'b0; x.m.s_c = 1'b1;
        return x;
    endfunction

    function automatic exp_t ctl(input exp_t x, input logic s, input logic rm,
                                 input logic [1:0] rs, input logic [2:0] sh, input logic [3:0] aop);
        x.v.s_c = s;   x.m.s_c = 1'b1;
        x.v.rm_c = rm; x.m.rm_c = 1'b1;
        x.v.rs_c = rs; x.m.rs_c = '1;
        x.v.sh_c = sh; x.m.sh_c = '1;
        x.v.aop = aop; x.m.aop = '1;
        return x;
    endfunction

    function automatic exp_t maddr(input string tag, input logic [3:0] aop);
        exp_t r;
        r = ex(tag, LF);
        r.v.rm_c = 1'b1;  r.m.rm_c = 1'b1;
        r.v.sh_c = 3'b0;  r.m.sh_c = '1;
        r.v.aop  = aop;   r.m.aop  = '1;
        r.v.s_c  = 1'b0;  r.m.s_c  = 1'b1;
        return r;
    endfunction

    task automatic step(input exp_t x);
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic step_fetch(input string tag);
        step(pc(ex(tag, WPC | WIR), 2'b00));
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check(cur.tag, {4'b0, sample() & cur.m}, {4'b0, cur.v & cur.m});
        end
    end

    initial begin
        rst = 1'b1; ir = '0; ir_valid = 1'b0; cond_fail = 1'b0; rm_imm_s = 1'b0;
        rs_imm_s = 2'b00; shift_op = 3'b000; alu_op = 4'b0000; s_bit = 1'b0; mem_ready = 1'b0;
        step(zero_all("reset0"));
        step(zero_all("reset1"));

        // ADD through WB; controls latched in EXEC and held afterwards
        rst = 1'b0; ir = 32'hE0810002; ir_valid = 1'b1;
        alu_op = 4'b0110; shift_op = 3'b101; rm_imm_s = 1'b1; rs_imm_s = 2'b10; s_bit = 1'b1;
        step_fetch("idle_to_fetch");
        step(ex("add_decode", LA | LB | LC));
        step(ctl(ex("add_exec", LF), 1'b1, 1'b1, 2'b10, 3'b101, 4'b0110));
        alu_op = 4'b0001; shift_op = 3'b011; rm_imm_s = 1'b0; rs_imm_s = 2'b01; s_bit = 1'b0;
        step(ctl(rdwd(ex("add_wb", WREG), 1'b0, 1'b0), 1'b1, 1'b1, 2'b10, 3'b101, 4'b0110));
        step_fetch("add_fetch");

        // data-processing skipped at EXEC
        ir = 32'hE0400001;
        step(ex("dp_decode", LA | LB | LC));
        step(ctl(ex("dp_exec", LF), 1'b0, 1'b0, 2'b01, 3'b011, 4'b0001));
        cond_fail = 1'b1;
        step_fetch("dp_condfail_skip");

        // B skipped in FETCH, then stall on !ir_valid, then taken
        ir = 32'hEA000010;
        step_fetch("b_condfail_stay");
        cond_fail = 1'b0; ir_valid = 1'b0;
        step_fetch("fetch_wait_valid");
        ir_valid = 1'b1;
        step(ab(ex("b_calc", LF), 1'b1, 1'b1, 4'b0100));
        step(ab(pc(rdwd(ex("b_wrpc", WPC), 1'b0, 1'b0), 2'b10), 1'b0, 1'b0, 4'b0100));
        step_fetch("b_fetch");

        // BX
        ir = 32'hE12FFF1E;
        step(ex("bx_decode", LA | LB | LC));
        step(pc(ex("bx", WPC), 2'b01));
        step_fetch("bx_fetch");

        // BL: link, calc, write PC
        ir = 32'hEB000010;
        cur = ex("bl_link", LF);
        cur.v.a_s = 1'b1; cur.m.a_s = 1'b1;
        cur.v.aop = 4'b1000; cur.m.aop = '1;
        cur.v.s_c = 1'b0; cur.m.s_c = 1'b1;
        step(cur);
        step(rdwd(ab(ex("bl_calc", LF | WREG), 1'b1, 1'b1, 4'b0100), 1'b1, 1'b0));
        step(rdwd(ab(pc(ex("bl_wrpc", WPC), 2'b10), 1'b0, 1'b0, 4'b0100), 1'b0, 1'b0));
        step_fetch("bl_fetch");

        // LDR, ready outside MEM_WAIT is ignored, ready on 3rd wait cycle
        ir = 32'hE5912004; mem_ready = 1'b1;
        step(ex("ldr_decode", LA | LB | LC));
        step(maddr("ldr_addr", 4'b0100));
        step(ex("ldr_wait1", MREQ));
        mem_ready = 1'b0;
        step(ex("ldr_wait2", MREQ));
        step(ex("ldr_wait3", MREQ));
        mem_ready = 1'b1;
        step(rdwd(ex("ldr_wb", WREG | LMDR), 1'b0, 1'b1));
        mem_ready = 1'b0;
        step_fetch("ldr_fetch");

        // LDR with U=0, reset while waiting
        ir = 32'hE5112004;
        step(ex("ldr_sub_decode", LA | LB | LC));
        step(maddr("ldr_sub_addr", 4'b0010));
        step(ex("ldr_sub_wait1", MREQ));
        step(ex("ldr_sub_wait2", MREQ));
        rst = 1'b1;
        step(zero_all("rst_mid_wait"));
        rst = 1'b0;
        step_fetch("rst_mid_fetch");

        // STR with no ready: 16 wait cycles then sticky fault
        ir = 32'hE5812004;
        step(ex("str_decode", LA | LB | LC));
        step(maddr("str_addr", 4'b0100));
        for (int i = 0; i < 16; i++) step(ex($sformatf("str_wait%0d", i), MREQ | MWE));
        step(ex("str_fault", FLT));
        mem_ready = 1'b1;
        step(ex("fault_sticky1", FLT));
        mem_ready = 1'b0;
        step(ex("fault_sticky2", FLT));
        rst = 1'b1;
        step(zero_all("fault_reset"));
        rst = 1'b0;
        step_fetch("fault_refetch");

        // STR with ready on the 16th wait cycle: completion wins
        step(ex("str2_decode", LA | LB | LC));
        step(maddr("str2_addr", 4'b0100));
        for (int i = 0; i < 16; i++) step(ex($sformatf("str2_wait%0d", i), MREQ | MWE));
        mem_ready = 1'b1;
        step_fetch("str2_done");
        mem_ready = 1'b0; ir_valid = 1'b0;
        step_fetch("str2_idle");

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
